// File: rtl/blackjack_game_pkg.sv
// Shared constants, FSM state encoding and card helpers for the 21 game engine.
package blackjack_game_pkg;

    localparam logic [4:0] STAND_LIMIT = 5'd17;
    localparam logic [3:0] FACE_VALUE  = 4'd10;
    localparam logic [3:0] MAX_RANK    = 4'd13;

    // Feedback taps of x^6+x^5+1, as bit indices into the 6-bit state
    localparam int LFSR_TAP_HI = 5;
    localparam int LFSR_TAP_LO = 4;

    typedef enum logic [1:0] {
        MASTER = 2'd0,
        SLAVE  = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic card_valid(input logic [3:0] rank);
        return (rank != 4'd0) && (rank <= MAX_RANK);
    endfunction

    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank > FACE_VALUE) ? FACE_VALUE : rank;
    endfunction

endpackage

// File: rtl/blackjack_game_lfsr6.sv
// 6-bit Fibonacci LFSR card source; one step per clock, seed load wins over stepping.
// A zero seed is replaced by 1 so the register can never lock up.
module lfsr6
    import blackjack_game_pkg::*;
(
    input  logic       clock,
    input  logic       load,
    input  logic [5:0] pdata6,
    output logic [5:0] pn6
);

    logic [5:0] pn_q;
    logic [5:0] pn_d;

    always_comb begin
        pn_d = {pn_q[4:0], pn_q[LFSR_TAP_HI] ^ pn_q[LFSR_TAP_LO]};
        if (load) begin
            pn_d = (pdata6 == 6'd0) ? 6'h01 : pdata6;
        end
    end

    always_ff @(posedge clock) begin
        pn_q <= pn_d;
    end

    assign pn6 = pn_q;

endmodule

// File: rtl/blackjack_game.sv
// Two-player 21 engine: deals one LFSR card per cycle to master, then slave, until each stands.
// Card effects are registered (1-cycle); the stand decision takes one extra cycle after the last draw.
module blackjack_game
    import blackjack_game_pkg::*;
(
    input  logic        clock,
    input  logic        new_Game,
    input  logic        load,
    input  logic [5:0]  pdata6,
    output logic [5:0]  pn6,
    output logic [3:0]  cardValue4,
    output logic [1:0]  color2,
    output logic [4:0]  totalValueMaster5,
    output logic [4:0]  totalValueSlave5,
    output logic        cardReadyMaster,
    output logic        cardReadySlave,
    output logic        finishMaster,
    output logic        finishSlave,
    output logic [2:0]  num_wire,
    output logic [15:0] bcdResults16
);

    state_e     state_q, state_d;
    logic [4:0] tot_m_q, tot_m_d;
    logic [4:0] tot_s_q, tot_s_d;
    logic [2:0] num_q, num_d;
    logic [3:0] card_q, card_d;
    logic [1:0] color_q, color_d;
    logic       fin_m_q, fin_m_d;
    logic       fin_s_q, fin_s_d;
    logic       rdy_m_q, rdy_m_d;
    logic       rdy_s_q, rdy_s_d;

    logic       draw_ok;
    logic [3:0] draw_val;
    logic [2:0] num_inc;

    lfsr6 u_lfsr (
        .clock  (clock),
        .load   (load),
        .pdata6 (pdata6),
        .pn6    (pn6)
    );

    assign draw_ok  = card_valid(pn6[3:0]);
    assign draw_val = card_value(pn6[3:0]);
    assign num_inc  = (num_q == 3'd7) ? 3'd7 : num_q + 3'd1;

    always_comb begin
        state_d = state_q;
        tot_m_d = tot_m_q;
        tot_s_d = tot_s_q;
        num_d   = num_q;
        card_d  = card_q;
        color_d = color_q;
        fin_m_d = fin_m_q;
        fin_s_d = fin_s_q;
        rdy_m_d = 1'b0;
        rdy_s_d = 1'b0;

        case (state_q)
            MASTER: begin
                if (tot_m_q >= STAND_LIMIT) begin
                    fin_m_d = 1'b1;
                    num_d   = 3'd0;
                    state_d = SLAVE;
                end else if (draw_ok) begin
                    tot_m_d = tot_m_q + {1'b0, draw_val};
                    card_d  = draw_val;
                    color_d = pn6[5:4];
                    rdy_m_d = 1'b1;
                    num_d   = num_inc;
                end
            end
            SLAVE: begin
                if (tot_s_q >= STAND_LIMIT) begin
                    fin_s_d = 1'b1;
                    num_d   = 3'd0;
                    state_d = DONE;
                end else if (draw_ok) begin
                    tot_s_d = tot_s_q + {1'b0, draw_val};
                    card_d  = draw_val;
                    color_d = pn6[5:4];
                    rdy_s_d = 1'b1;
                    num_d   = num_inc;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = MASTER;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (new_Game) begin
            state_q <= MASTER;
            tot_m_q <= 5'd0;
            tot_s_q <= 5'd0;
            num_q   <= 3'd0;
            card_q  <= 4'd0;
            color_q <= 2'd0;
            fin_m_q <= 1'b0;
            fin_s_q <= 1'b0;
            rdy_m_q <= 1'b0;
            rdy_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tot_m_q <= tot_m_d;
            tot_s_q <= tot_s_d;
            num_q   <= num_d;
            card_q  <= card_d;
            color_q <= color_d;
            fin_m_q <= fin_m_d;
            fin_s_q <= fin_s_d;
            rdy_m_q <= rdy_m_d;
            rdy_s_q <= rdy_s_d;
        end
    end

    // Double-dabble: totals never exceed 26, so two BCD digits suffice
    function automatic logic [7:0] bin2bcd(input logic [4:0] bin);
        logic [12:0] sh;
        sh = {8'd0, bin};
        for (int i = 0; i < 5; i++) begin
            if (sh[8:5] >= 4'd5)  sh[8:5]  = sh[8:5] + 4'd3;
            if (sh[12:9] >= 4'd5) sh[12:9] = sh[12:9] + 4'd3;
            sh = sh << 1;
        end
        return sh[12:5];
    endfunction

    assign cardValue4        = card_q;
    assign color2            = color_q;
    assign totalValueMaster5 = tot_m_q;
    assign totalValueSlave5  = tot_s_q;
    assign cardReadyMaster   = rdy_m_q;
    assign cardReadySlave    = rdy_s_q;
    assign finishMaster      = fin_m_q;
    assign finishSlave       = fin_s_q;
    assign num_wire          = num_q;
    assign bcdResults16      = {bin2bcd(tot_m_q), bin2bcd(tot_s_q)};

endmodule

// File: tb/tb_blackjack_game.sv
// Directed bench for blackjack_game: LFSR sequence, zero seed, a full game from seed 0x13,
// frozen DONE outputs and a mid-game restart.
module tb_blackjack_game;

    logic        clock = 1'b0;
    logic        new_Game;
    logic        load;
    logic [5:0]  pdata6;
    logic [5:0]  pn6;
    logic [3:0]  cardValue4;
    logic [1:0]  color2;
    logic [4:0]  totalValueMaster5;
    logic [4:0]  totalValueSlave5;
    logic        cardReadyMaster;
    logic        cardReadySlave;
    logic        finishMaster;
    logic        finishSlave;
    logic [2:0]  num_wire;
    logic [15:0] bcdResults16;

    int n_vec = 0;
    int n_err = 0;

    blackjack_game dut (
        .clock             (clock),
        .new_Game          (new_Game),
        .load              (load),
        .pdata6            (pdata6),
        .pn6               (pn6),
        .cardValue4        (cardValue4),
        .color2            (color2),
        .totalValueMaster5 (totalValueMaster5),
        .totalValueSlave5  (totalValueSlave5),
        .cardReadyMaster   (cardReadyMaster),
        .cardReadySlave    (cardReadySlave),
        .finishMaster      (finishMaster),
        .finishSlave       (finishSlave),
        .num_wire          (num_wire),
        .bcdResults16      (bcdResults16)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected state after each game edge, seed 0x13, hand-derived from the LFSR walk
    typedef struct {
        logic [1:0] rdy;   // {master, slave}
        logic [4:0] tm;
        logic [4:0] ts;
        logic [2:0] num;
        logic [3:0] card;
        logic [1:0] col;
        logic [1:0] fin;   // {master, slave}
    } row_t;

    row_t rows [12];

    logic [23:0] frozen_exp;

    function automatic logic [23:0] snap(input logic [1:0] rdy, input logic [1:0] fin,
                                         input logic [4:0] tm, input logic [4:0] ts,
                                         input logic [2:0] num, input logic [3:0] card,
                                         input logic [1:0] col);
        return {1'b0, rdy, fin, tm, ts, num, card, col};
    endfunction

    initial begin
        rows[0]  = '{2'b10, 5'd3,  5'd0,  3'd1, 4'd3,  2'd1, 2'b00}; // 0x13 rank 3
        rows[1]  = '{2'b10, 5'd10, 5'd0,  3'd2, 4'd7,  2'd2, 2'b00}; // 0x27 rank 7
        rows[2]  = '{2'b00, 5'd10, 5'd0,  3'd2, 4'd7,  2'd2, 2'b00}; // 0x0F rank 15
        rows[3]  = '{2'b00, 5'd10, 5'd0,  3'd2, 4'd7,  2'd2, 2'b00}; // 0x1E rank 14
        rows[4]  = '{2'b10, 5'd20, 5'd0,  3'd3, 4'd10, 2'd3, 2'b00}; // 0x3D king
        rows[5]  = '{2'b00, 5'd20, 5'd0,  3'd0, 4'd10, 2'd3, 2'b10}; // master stands
        rows[6]  = '{2'b01, 5'd20, 5'd4,  3'd1, 4'd4,  2'd3, 2'b10}; // 0x34
        rows[7]  = '{2'b01, 5'd20, 5'd12, 3'd2, 4'd8,  2'd2, 2'b10}; // 0x28
        rows[8]  = '{2'b01, 5'd20, 5'd13, 3'd3, 4'd1,  2'd1, 2'b10}; // 0x11 ace
        rows[9]  = '{2'b01, 5'd20, 5'd16, 3'd4, 4'd3,  2'd2, 2'b10}; // 0x23
        rows[10] = '{2'b01, 5'd20, 5'd23, 3'd5, 4'd7,  2'd0, 2'b10}; // 0x07, slave busts
        rows[11] = '{2'b00, 5'd20, 5'd23, 3'd0, 4'd7,  2'd0, 2'b11}; // slave done

        new_Game = 1'b1;
        load     = 1'b1;
        pdata6   = 6'h13;

        // Seed load while the game is held in reset
        tick();
        load = 1'b0;
        check("rst tot_m",  32'(totalValueMaster5), 32'd0);
        check("rst tot_s",  32'(totalValueSlave5),  32'd0);
        check("rst num",    32'(num_wire),          32'd0);
        check("rst card",   32'({cardValue4, color2}), 32'd0);
        check("rst flags",  32'({cardReadyMaster, cardReadySlave, finishMaster, finishSlave}), 32'd0);
        check("rst bcd",    32'(bcdResults16),      32'd0);
        check("seed pn0",   32'(pn6),               32'h13);
        tick(); check("seed pn1", 32'(pn6), 32'h27);
        tick(); check("seed pn2", 32'(pn6), 32'h0F);
        tick(); check("seed pn3", 32'(pn6), 32'h1E);
        tick(); check("seed pn4", 32'(pn6), 32'h3D);
        check("held no deal", 32'({cardReadyMaster, totalValueMaster5}), 32'd0);

        // Zero seed substitutes 1
        load = 1'b1; pdata6 = 6'h00;
        tick(); load = 1'b0;
        check("zero seed", 32'(pn6), 32'h01);
        tick(); check("zero step1", 32'(pn6), 32'h02);
        tick(); check("zero step2", 32'(pn6), 32'h04);

        // Full game: simultaneous load and new_Game, then release
        load = 1'b1; pdata6 = 6'h13; new_Game = 1'b1;
        tick();
        load = 1'b0; new_Game = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("E%0d rdy", i + 1),   32'({cardReadyMaster, cardReadySlave}), 32'(rows[i].rdy));
            check($sformatf("E%0d tot_m", i + 1), 32'(totalValueMaster5), 32'(rows[i].tm));
            check($sformatf("E%0d tot_s", i + 1), 32'(totalValueSlave5),  32'(rows[i].ts));
            check($sformatf("E%0d num", i + 1),   32'(num_wire),          32'(rows[i].num));
            check($sformatf("E%0d card", i + 1),  32'({cardValue4, color2}), 32'({rows[i].card, rows[i].col}));
            check($sformatf("E%0d fin", i + 1),   32'({finishMaster, finishSlave}), 32'(rows[i].fin));
        end
        check("done bcd", 32'(bcdResults16), 32'h2023);

        // DONE holds every game output
        frozen_exp = snap(2'b00, 2'b11, 5'd20, 5'd23, 3'd0, 4'd7, 2'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check($sformatf("hold %0d", i),
                  32'(snap({cardReadyMaster, cardReadySlave}, {finishMaster, finishSlave},
                           totalValueMaster5, totalValueSlave5, num_wire, cardValue4, color2)),
                  32'(frozen_exp));
        end
        check("hold bcd", 32'(bcdResults16), 32'h2023);

        // Abort a game while two master cards are held
        load = 1'b1; pdata6 = 6'h13; new_Game = 1'b1;
        tick();
        load = 1'b0; new_Game = 1'b0;
        tick();
        tick();
        check("mid num2", 32'(num_wire), 32'd2);
        check("mid tot2", 32'(totalValueMaster5), 32'd10);
        new_Game = 1'b1;
        tick();
        new_Game = 1'b0;
        check("abort tots", 32'({totalValueMaster5, totalValueSlave5}), 32'd0);
        check("abort num",  32'(num_wire), 32'd0);
        check("abort card", 32'({cardValue4, color2}), 32'd0);
        check("abort flags", 32'({cardReadyMaster, cardReadySlave, finishMaster, finishSlave}), 32'd0);
        check("abort bcd",  32'(bcdResults16), 32'd0);
        tick(); // pn6 0x1E: rank 14, nothing dealt
        check("restart idle", 32'({cardReadyMaster, totalValueMaster5}), 32'd0);
        tick(); // pn6 0x3D: king to master
        check("restart rdy",  32'({cardReadyMaster, cardReadySlave}), 32'b10);
        check("restart tot",  32'(totalValueMaster5), 32'd10);
        check("restart num",  32'(num_wire), 32'd1);
        check("restart card", 32'({cardValue4, color2}), 32'({4'd10, 2'd3}));
        check("restart bcd",  32'(bcdResults16), 32'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
